// File: rtl/ad4003_pkg.sv
// ad4003_pkg: shared modes, frame lengths, default command bytes and FSM state type
package ad4003_pkg;
   localparam logic [1:0] MODE_IDLE = 2'b00;
   localparam logic [1:0] MODE_CFG  = 2'b10;
   localparam logic [1:0] MODE_READ = 2'b11;
   localparam logic [1:0] MODE_ACQ  = 2'b01;
   localparam int LEN_REG = 16;
   localparam int LEN_ACQ = 18;
   localparam logic [7:0] DEF_CFG_DATA = 8'h02;
   localparam logic [7:0] DEF_WR_CMD   = 8'h14;
   localparam logic [7:0] DEF_RD_CMD   = 8'h54;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/ad4003_deserializer_if.sv
// ad4003_deserializer_if: frame control, ADC serial pins and parallel results
interface ad4003_deserializer_if;
   logic        word_sync_n;
   logic        adc_start_conv;
   logic [1:0]  mode;
   logic        serial_data_a_p, serial_data_a_n;
   logic        serial_data_b_p, serial_data_b_n;
   logic        serial_clock_p, serial_clock_n;
   logic        serial_sdi_p, serial_sdi_n;
   logic [17:0] parallel_data_a, parallel_data_b;
   logic        adc_config_status;
   logic        serial_data_a_o, serial_data_b_o, serial_clock_o, serial_sdi_o;
   logic        cnt_77_lsb_o;
   modport master (
      input  word_sync_n, adc_start_conv, mode,
             serial_data_a_p, serial_data_a_n, serial_data_b_p, serial_data_b_n,
      output serial_clock_p, serial_clock_n, serial_sdi_p, serial_sdi_n,
             parallel_data_a, parallel_data_b, adc_config_status,
             serial_data_a_o, serial_data_b_o, serial_clock_o, serial_sdi_o, cnt_77_lsb_o
   );
   modport slave (
      output word_sync_n, adc_start_conv, mode,
             serial_data_a_p, serial_data_a_n, serial_data_b_p, serial_data_b_n,
      input  serial_clock_p, serial_clock_n, serial_sdi_p, serial_sdi_n,
             parallel_data_a, parallel_data_b, adc_config_status,
             serial_data_a_o, serial_data_b_o, serial_clock_o, serial_sdi_o, cnt_77_lsb_o
   );
endinterface

// File: rtl/ad4003_lane_shift.sv
// ad4003_lane_shift: per-lane SDO shift register with snapshot of the completed word
module ad4003_lane_shift
   import ad4003_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               sample,
   input  logic               load,
   input  logic               sdo,
   output logic [7:0]         tail,
   output logic [LEN_ACQ-1:0] snap_q
);
   logic [LEN_ACQ-1:0] shift_q, shift_d, snap_d;
   always_comb begin
      shift_d = sample ? {shift_q[LEN_ACQ-2:0], sdo} : shift_q;
      snap_d  = load ? shift_q : snap_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         shift_q <= '0;
         snap_q  <= '0;
      end else begin
         shift_q <= shift_d;
         snap_q  <= snap_d;
      end
   assign tail = shift_q[7:0];
endmodule

// File: rtl/ad4003_deserializer.sv
// ad4003_deserializer: SPI master for two AD4003 ADCs sharing SCK/SDI;
// per frame writes config, reads it back, or captures one 18-bit sample per lane.
module ad4003_deserializer
   import ad4003_pkg::*;
#(
   parameter int         SCK_HALF = 1,
   parameter logic [7:0] CFG_DATA = DEF_CFG_DATA,
   parameter logic [7:0] WR_CMD   = DEF_WR_CMD,
   parameter logic [7:0] RD_CMD   = DEF_RD_CMD
) (
   input logic clk_100,
   input logic rst,
   ad4003_deserializer_if.master io
);
   localparam int DW = SCK_HALF > 1 ? $clog2(SCK_HALF) : 1;
   state_t          state_q, state_d;
   logic [1:0]      mode_q, mode_d;
   logic            ws_q, ws_d, sck_q, sck_d, sdi_q, sdi_d, status_q, status_d, hp_q, hp_d;
   logic [15:0]     sdi_sr_q, sdi_sr_d, seq;
   logic [DW-1:0]   div_q, div_d;
   logic [4:0]      bit_q, bit_d, len;
   logic            start, tick, fall, load;
   logic [7:0]      tail_a, tail_b;
   logic            unused_n;
   assign seq   = io.mode == MODE_READ ? {RD_CMD, 8'h00} : io.mode == MODE_CFG ? {WR_CMD, CFG_DATA} : 16'hFFFF;
   assign start = ws_q && !io.word_sync_n && !io.adc_start_conv && io.mode != MODE_IDLE;
   assign tick  = div_q == DW'(SCK_HALF - 1);
   assign fall  = state_q == SHIFT && tick && sck_q;
   assign load  = state_q == DONE && mode_q == MODE_ACQ;
   assign len   = mode_q == MODE_ACQ ? 5'(LEN_ACQ) : 5'(LEN_REG);
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      ws_d     = io.word_sync_n;
      sck_d    = sck_q;
      sdi_d    = sdi_q;
      sdi_sr_d = sdi_sr_q;
      div_d    = div_q;
      bit_d    = bit_q;
      hp_d     = hp_q;
      status_d = status_q;
      case (state_q)
         IDLE: if (start) begin
            state_d  = SHIFT;
            mode_d   = io.mode;
            sck_d    = 1'b1;
            sdi_d    = seq[15];
            sdi_sr_d = {seq[14:0], 1'b1};
            div_d    = '0;
            bit_d    = '0;
            hp_d     = 1'b0;
            status_d = io.mode == MODE_CFG ? 1'b0 : status_q;
         end
         SHIFT: if (tick) begin
            div_d = '0;
            sck_d = ~sck_q;
            hp_d  = ~hp_q;
            // SDI advances and SDO is sampled on the SCK falling edge
            if (sck_q) begin
               bit_d    = bit_q + 5'd1;
               sdi_d    = sdi_sr_q[15];
               sdi_sr_d = {sdi_sr_q[14:0], 1'b1};
               state_d  = bit_q + 5'd1 == len ? DONE : SHIFT;
            end
         end else div_d = div_q + DW'(1);
         DONE: begin
            state_d  = IDLE;
            status_d = mode_q == MODE_READ ? (tail_a == CFG_DATA && tail_b == CFG_DATA) : status_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_100 or posedge rst)
      if (rst) begin
         state_q  <= IDLE;
         mode_q   <= MODE_IDLE;
         ws_q     <= 1'b0;
         sck_q    <= 1'b0;
         sdi_q    <= 1'b1;
         sdi_sr_q <= '1;
         div_q    <= '0;
         bit_q    <= '0;
         hp_q     <= 1'b0;
         status_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         ws_q     <= ws_d;
         sck_q    <= sck_d;
         sdi_q    <= sdi_d;
         sdi_sr_q <= sdi_sr_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         hp_q     <= hp_d;
         status_q <= status_d;
      end
   ad4003_lane_shift u_lane_a (.clk(clk_100), .rst(rst), .sample(fall), .load(load),
      .sdo(io.serial_data_a_p), .tail(tail_a), .snap_q(io.parallel_data_a));
   ad4003_lane_shift u_lane_b (.clk(clk_100), .rst(rst), .sample(fall), .load(load),
      .sdo(io.serial_data_b_p), .tail(tail_b), .snap_q(io.parallel_data_b));
   assign unused_n             = &{1'b0, io.serial_data_a_n, io.serial_data_b_n};
   assign io.serial_clock_p    = sck_q;
   assign io.serial_clock_n    = ~sck_q;
   assign io.serial_sdi_p      = sdi_q;
   assign io.serial_sdi_n      = ~sdi_q;
   assign io.adc_config_status = status_q;
   assign io.serial_data_a_o   = io.serial_data_a_p;
   assign io.serial_data_b_o   = io.serial_data_b_p;
   assign io.serial_clock_o    = sck_q;
   assign io.serial_sdi_o      = sdi_q;
   assign io.cnt_77_lsb_o      = hp_q;
endmodule

// File: tb/tb_ad4003_deserializer.sv
// tb_ad4003_deserializer: drives ADC-like SDO per SCK fall and checks frames against a behavioural model
module tb_ad4003_deserializer;
   import ad4003_pkg::*;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   ad4003_deserializer_if io();
   ad4003_deserializer dut (.clk_100(clk), .rst(rst), .io(io));
   int n_cmp = 0;
   int n_fail = 0;
   logic [17:0] exp_pa = '0;
   logic [17:0] exp_pb = '0;
   logic        exp_st = 1'b0;

   task automatic drive_sdo(input logic a, input logic b);
      io.serial_data_a_p = a;
      io.serial_data_a_n = ~a;
      io.serial_data_b_p = b;
      io.serial_data_b_n = ~b;
   endtask

   task automatic run_frame(input logic [1:0] m, input logic [17:0] wa, input logic [17:0] wb,
                            input int rise_at, input bit glitch, input int pad);
      int len, falls, rises;
      logic prev, n_ok, quiet;
      logic [17:0] got_sdi, want_sdi, old_pa, old_pb;
      len      = m == MODE_ACQ ? 18 : 16;
      want_sdi = m == MODE_CFG ? 18'h01402 : m == MODE_READ ? 18'h05400 : 18'h3FFFF;
      falls = 0; rises = 0; prev = 1'b0; n_ok = 1'b1; quiet = 1'b1; got_sdi = '0;
      old_pa = exp_pa; old_pb = exp_pb;
      @(negedge clk);
      io.mode = m;
      drive_sdo(wa[len-1], wb[len-1]);
      io.word_sync_n = 1'b0;
      for (int k = 0; k < 2*len + 6; k++) begin
         @(negedge clk);
         if (io.serial_clock_p && !prev) begin
            got_sdi = {got_sdi[16:0], io.serial_sdi_p};
            rises++;
         end
         if (!io.serial_clock_p && prev) begin
            falls++;
            if (falls < len) drive_sdo(wa[len-1-falls], wb[len-1-falls]);
            if (falls == 2) io.mode = 2'($urandom);
            if (falls == rise_at) io.word_sync_n = 1'b1;
            if (glitch && falls == rise_at + 3) io.word_sync_n = 1'b0;
         end
         prev = io.serial_clock_p;
         if (io.serial_clock_n !== ~io.serial_clock_p || io.serial_sdi_n !== ~io.serial_sdi_p ||
             io.serial_clock_o !== io.serial_clock_p || io.serial_sdi_o !== io.serial_sdi_p ||
             io.serial_data_a_o !== io.serial_data_a_p || io.serial_data_b_o !== io.serial_data_b_p) n_ok = 1'b0;
         if (m == MODE_ACQ && k == 35) begin
            n_cmp++;
            if ({io.parallel_data_a, io.parallel_data_b} !== {old_pa, old_pb}) begin
               n_fail++;
               $display("FAIL early_update: got %h/%h expected %h/%h at E35", io.parallel_data_a, io.parallel_data_b, old_pa, old_pb);
            end
         end
         if (m == MODE_ACQ && k == 36) begin
            n_cmp++;
            if ({io.parallel_data_a, io.parallel_data_b} !== {wa, wb}) begin
               n_fail++;
               $display("FAIL update_e36: got %h/%h expected %h/%h", io.parallel_data_a, io.parallel_data_b, wa, wb);
            end
         end
      end
      io.word_sync_n = 1'b1;
      if (m == MODE_ACQ) begin exp_pa = wa; exp_pb = wb; end
      if (m == MODE_READ) exp_st = wa[7:0] == 8'h02 && wb[7:0] == 8'h02;
      if (m == MODE_CFG) exp_st = 1'b0;
      n_cmp++;
      if (falls != len || rises != len) begin
         n_fail++;
         $display("FAIL sck_pulses: got %0d falls %0d rises expected %0d", falls, rises, len);
      end
      n_cmp++;
      if (got_sdi !== want_sdi) begin
         n_fail++;
         $display("FAIL sdi_pattern: got %h expected %h (mode %b)", got_sdi, want_sdi, m);
      end
      n_cmp++;
      if (io.parallel_data_a !== exp_pa || io.parallel_data_b !== exp_pb) begin
         n_fail++;
         $display("FAIL parallel: got %h/%h expected %h/%h", io.parallel_data_a, io.parallel_data_b, exp_pa, exp_pb);
      end
      n_cmp++;
      if (io.adc_config_status !== exp_st) begin
         n_fail++;
         $display("FAIL status: got %b expected %b (mode %b)", io.adc_config_status, exp_st, m);
      end
      n_cmp++;
      if (!n_ok) begin
         n_fail++;
         $display("FAIL complement_debug: got mismatch expected _n = ~_p and debug copies equal");
      end
      for (int k = 0; k < pad; k++) begin
         @(negedge clk);
         if (io.serial_clock_p !== 1'b0 || io.serial_sdi_p !== 1'b1) quiet = 1'b0;
      end
      n_cmp++;
      if (!quiet) begin
         n_fail++;
         $display("FAIL idle_quiet: got SCK/SDI activity expected SCK=0 SDI=1 after frame");
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      io.word_sync_n = 1'b1;
      io.adc_start_conv = 1'b0;
      io.mode = MODE_IDLE;
      drive_sdo(1'b0, 1'b0);
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({io.serial_clock_p, io.serial_clock_n, io.serial_sdi_p, io.serial_sdi_n} !== 4'b0110 ||
          io.parallel_data_a !== '0 || io.parallel_data_b !== '0 || io.adc_config_status !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got sck=%b sdi=%b pa=%h pb=%h st=%b expected sck=0 sdi=1 zeros",
                  io.serial_clock_p, io.serial_sdi_p, io.parallel_data_a, io.parallel_data_b, io.adc_config_status);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_config;
      run_frame(MODE_CFG, 18'($urandom), 18'($urandom), 3, 1'b0, 10);
   endtask

   task automatic test_readback;
      run_frame(MODE_READ, {2'b00, 8'($urandom), 8'h02}, {2'b00, 8'($urandom), 8'h02}, 4, 1'b0, 10);
      run_frame(MODE_READ, {2'b00, 8'($urandom), 8'h02}, {2'b00, 8'($urandom), 8'h00}, 4, 1'b0, 10);
   endtask

   task automatic test_acquire;
      run_frame(MODE_ACQ, 18'h2A5C3, 18'h15A3C, 5, 1'b0, 10);
      run_frame(MODE_ACQ, 18'($urandom), 18'($urandom), 5, 1'b1, 10);
   endtask

   task automatic test_random;
      logic [1:0] m;
      for (int i = 0; i < 8; i++) begin
         m = 2'($urandom_range(1, 3));
         run_frame(m, $urandom_range(0, 1) ? {10'($urandom), 8'h02} : 18'($urandom),
                   $urandom_range(0, 1) ? {10'($urandom), 8'h02} : 18'($urandom),
                   $urandom_range(1, 10), 1'($urandom), 5);
      end
   endtask

   task automatic test_gating(input logic conv, input logic [1:0] m);
      logic quiet;
      quiet = 1'b1;
      @(negedge clk);
      io.adc_start_conv = conv;
      io.mode = m;
      io.word_sync_n = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (io.serial_clock_p !== 1'b0 || io.serial_sdi_p !== 1'b1) quiet = 1'b0;
      end
      io.word_sync_n = 1'b1;
      @(negedge clk);
      io.adc_start_conv = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (!quiet) begin
         n_fail++;
         $display("FAIL gating_sck: got SCK activity expected none (conv=%b mode=%b)", conv, m);
      end
      n_cmp++;
      if (io.parallel_data_a !== exp_pa || io.parallel_data_b !== exp_pb || io.adc_config_status !== exp_st) begin
         n_fail++;
         $display("FAIL gating_outputs: got %h/%h/%b expected %h/%h/%b", io.parallel_data_a, io.parallel_data_b,
                  io.adc_config_status, exp_pa, exp_pb, exp_st);
      end
   endtask

   task automatic test_back_to_back;
      run_frame(MODE_CFG, 18'($urandom), 18'($urandom), 3, 1'b0, 60 - 39);
      run_frame(MODE_READ, {10'($urandom), 8'h02}, {10'($urandom), 8'h02}, 3, 1'b0, 60 - 39);
      n_cmp++;
      if (io.adc_config_status !== 1'b1) begin
         n_fail++;
         $display("FAIL seq_status: got %b expected 1", io.adc_config_status);
      end
      run_frame(MODE_ACQ, 18'($urandom), 18'($urandom), 3, 1'b0, 60 - 43);
      run_frame(MODE_ACQ, 18'($urandom), 18'($urandom), 3, 1'b0, 60 - 43);
   endtask

   task automatic test_reset_midframe;
      @(negedge clk);
      io.mode = MODE_ACQ;
      drive_sdo(1'b1, 1'b1);
      io.word_sync_n = 1'b0;
      repeat (10) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      exp_pa = '0; exp_pb = '0; exp_st = 1'b0;
      n_cmp++;
      if ({io.serial_clock_p, io.serial_clock_n, io.serial_sdi_p, io.serial_sdi_n} !== 4'b0110 ||
          io.parallel_data_a !== '0 || io.parallel_data_b !== '0 || io.adc_config_status !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_midframe: got sck=%b sckn=%b sdi=%b pa=%h pb=%h st=%b expected 0 1 1 0 0 0",
                  io.serial_clock_p, io.serial_clock_n, io.serial_sdi_p, io.parallel_data_a,
                  io.parallel_data_b, io.adc_config_status);
      end
      io.word_sync_n = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      run_frame(MODE_ACQ, 18'($urandom), 18'($urandom), 6, 1'b0, 5);
   endtask

   initial begin
      test_reset;
      test_config;
      test_readback;
      test_acquire;
      test_random;
      test_gating(1'b1, MODE_ACQ);
      test_gating(1'b0, MODE_IDLE);
      test_back_to_back;
      test_reset_midframe;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
